// File: rtl/ula_seq.sv
// ula_seq: registered ALU with valid/ready handshake and status flags.
// Multiply is an iterative shift-add taking WIDTH+1 cycles.
module ula_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       tula,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outp,
  output logic [WIDTH-1:0] outp_hi,
  output logic             stat,
  output logic             flg_z,
  output logic             flg_c,
  output logic             flg_v,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     psum;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [SW-1:0]      n;
  logic [WIDTH-1:0]   r;
  logic               rs, rc, rv, ril;
  logic               acc;
  logic               is_mul;

  assign acc    = in_valid & in_ready;
  assign is_mul = MUL_EN && (tula == 4'b1100);
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign n      = b[SW-1:0];
  assign psum   = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, mcand} : '0);

  assign out_valid = (state == DONE);

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    r   = '0;
    rs  = 1'b0;
    rc  = 1'b0;
    rv  = 1'b0;
    ril = 1'b0;
    case (tula)
      4'b0000: begin
        r  = add_w[WIDTH-1:0];
        rc = add_w[WIDTH];
        rv = (a[WIDTH-1] == b[WIDTH-1]) &&
             (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        r  = sub_w[WIDTH-1:0];
        rc = sub_w[WIDTH];
        rv = (a[WIDTH-1] != b[WIDTH-1]) &&
             (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: begin
        r  = '0 - b;
        rv = (b == {1'b1, {(WIDTH-1){1'b0}}});
      end
      4'b0011: begin
        rs = (a == b);
        r  = {{(WIDTH-1){1'b0}}, rs};
      end
      4'b0100: begin
        rs = (a > b);
        r  = {{(WIDTH-1){1'b0}}, rs};
      end
      4'b0101: begin
        rs = (a < b);
        r  = {{(WIDTH-1){1'b0}}, rs};
      end
      4'b1101: begin
        rs = ($signed(a) < $signed(b));
        r  = {{(WIDTH-1){1'b0}}, rs};
      end
      4'b0110: r = a & b;
      4'b0111: r = a ^ b;
      4'b1000: r = a | b;
      4'b1001: r = a << n;
      4'b1010: r = a >> n;
      4'b1011: r = $signed(a) >>> n;
      4'b1100: ril = !MUL_EN;
      default: ril = 1'b1;
    endcase
  end

  // The cycle after the last shift-add step registers product and flags.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid)
          state_nx = is_mul ? MUL : DONE;
      end
      MUL: begin
        if (cnt == '0)
          state_nx = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nx = in_valid ? (is_mul ? MUL : DONE) : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      outp    <= '0;
      outp_hi <= '0;
      stat    <= 1'b0;
      flg_z   <= 1'b0;
      flg_c   <= 1'b0;
      flg_v   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (acc && is_mul) begin
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        cnt   <= CNT_INIT;
      end else if (state == MUL && cnt != '0) begin
        prod <= {psum, prod[WIDTH-1:1]};
        cnt  <= cnt - CW'(1);
      end
      if (acc && !is_mul) begin
        outp    <= r;
        outp_hi <= '0;
        stat    <= rs;
        flg_z   <= (r == '0) && !ril;
        flg_c   <= rc;
        flg_v   <= rv;
        illegal <= ril;
      end else if (state == MUL && cnt == '0) begin
        outp    <= prod[WIDTH-1:0];
        outp_hi <= prod[2*WIDTH-1:WIDTH];
        stat    <= 1'b0;
        flg_z   <= (prod == '0);
        flg_c   <= (prod[2*WIDTH-1:WIDTH] != '0);
        flg_v   <= 1'b0;
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed stimulus with a result scoreboard for ula_seq.
// Results are compared when the consumer handshake completes.
module tb_ula_seq;

  typedef struct packed {
    logic [7:0] o;
    logic [7:0] hi;
    logic       st;
    logic       z;
    logic       c;
    logic       v;
    logic       il;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] tula;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outp;
  logic [7:0] outp_hi;
  logic       stat;
  logic       flg_z;
  logic       flg_c;
  logic       flg_v;
  logic       illegal;

  int   total;
  int   bad;
  exp_t q[$];

  ula_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tula      (tula),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .outp_hi   (outp_hi),
    .stat      (stat),
    .flg_z     (flg_z),
    .flg_c     (flg_c),
    .flg_v     (flg_v),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x,
                                 input logic [7:0] y,
                                 input logic [3:0] op);
    exp_t e;
    int   ux, uy, sx, sy, t, sh;
    e  = '0;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = int'(y[2:0]);
    case (op)
      4'd0: begin
        t = ux + uy;  e.o = 8'(t); e.c = (t > 255);
        t = sx + sy;  e.v = (t > 127) || (t < -128);
      end
      4'd1: begin
        t = ux - uy;  e.o = 8'(t); e.c = (ux < uy);
        t = sx - sy;  e.v = (t > 127) || (t < -128);
      end
      4'd2: begin
        e.o = 8'(-uy); e.v = (uy == 128);
      end
      4'd3:  begin e.st = (ux == uy); e.o = {7'd0, e.st}; end
      4'd4:  begin e.st = (ux > uy);  e.o = {7'd0, e.st}; end
      4'd5:  begin e.st = (ux < uy);  e.o = {7'd0, e.st}; end
      4'd13: begin e.st = (sx < sy);  e.o = {7'd0, e.st}; end
      4'd6:  e.o = x & y;
      4'd7:  e.o = x ^ y;
      4'd8:  e.o = x | y;
      4'd9:  e.o = 8'(ux << sh);
      4'd10: e.o = 8'(ux >> sh);
      4'd11: e.o = 8'(sx >>> sh);
      4'd12: begin
        t = ux * uy; e.o = 8'(t); e.hi = 8'(t >> 8);
        e.c = (e.hi != 8'd0);
      end
      default: e.il = 1'b1;
    endcase
    e.z = !e.il && (e.o == 8'd0) && (e.hi == 8'd0);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] op, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    a = x; b = y; tula = op; in_valid = 1'b1;
    while (!done && waits < 60) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      waits++;
    end
    chk("accept", 32'(done), 32'd1);
    if (done) q.push_back(model(x, y, op));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int   w;
    int   k;
    exp_t e;
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; tula = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(q.size()), 32'd1);
          end else begin
            e = q.pop_front();
            chk("scoreboard",
                32'({outp, outp_hi, stat, flg_z, flg_c, flg_v, illegal}),
                32'(e));
          end
        end
      end
    join_none

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({outp, outp_hi, stat, flg_z, flg_c, flg_v,
                         illegal}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'hF0, 8'h20, 4'd0, w);
    chk("add_lat", 32'(out_valid), 32'd1);
    chk("add_res", 32'({outp, flg_c, flg_v, flg_z}), {8'h10, 3'b100});
    send(8'h7F, 8'h01, 4'd0, w);
    chk("add_ovf", 32'({outp, flg_c, flg_v}), {8'h80, 2'b01});
    send(8'h03, 8'h05, 4'd1, w);
    chk("sub_brw", 32'({outp, flg_c}), {8'hFE, 1'b1});
    send(8'h80, 8'h01, 4'd4, w);
    chk("cmp_gt", 32'({outp, stat}), {8'h01, 1'b1});
    send(8'h80, 8'h01, 4'd13, w);
    chk("cmp_slt", 32'({outp, stat}), {8'h01, 1'b1});
    send(8'h80, 8'h01, 4'd3, w);
    chk("cmp_eq", 32'({outp, stat}), {8'h00, 1'b0});
    drain();

    pa[0] = 8'hA5; pb[0] = 8'h3C;
    pa[1] = 8'h00; pb[1] = 8'h00;
    pa[2] = 8'h80; pb[2] = 8'h7F;
    pa[3] = 8'hFF; pb[3] = 8'hF9;
    for (int i = 0; i < 4; i++)
      for (int op = 0; op < 16; op++)
        send(pa[i], pb[i], 4'(op), w);
    drain();

    send(8'hFF, 8'hFF, 4'd12, w);
    k = 0;
    while (!out_valid && k < 30) begin
      chk("mul_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      k++;
    end
    chk("mul_lat", 32'(k), 32'd9);
    chk("mul_res", 32'({outp_hi, outp, flg_c}), {8'hFE, 8'h01, 1'b1});
    drain();

    out_ready = 1'b0;
    send(8'h5A, 8'h0F, 4'd7, w);
    a = 8'h11; b = 8'h22; tula = 4'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", 32'({out_valid, in_ready, outp}), {2'b10, 8'h55});
    end
    out_ready = 1'b1;
    send(8'h11, 8'h22, 4'd7, w);
    chk("stream_w0", 32'(w), 32'd1);
    send(8'h33, 8'h0F, 4'd7, w);
    chk("stream_w1", 32'(w), 32'd1);
    send(8'hC3, 8'h81, 4'd7, w);
    chk("stream_w2", 32'(w), 32'd1);
    send(8'h96, 8'h69, 4'd7, w);
    chk("stream_w3", 32'(w), 32'd1);
    drain();

    send(8'h12, 8'h34, 4'd12, w);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_outs", 32'({outp, outp_hi, stat, flg_z, flg_c, flg_v,
                          illegal}), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h0D, 8'h0B, 4'd12, w);
    drain();
    chk("post_rst_mul", 32'({outp_hi, outp}), 32'h008F);
    send(8'h01, 8'h02, 4'd14, w);
    chk("illegal", 32'({illegal, outp, flg_z}), {1'b1, 8'h00, 1'b0});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
